// File: rtl/rdft_pkg.sv
// Shared definitions for the rdft/irdft datapath: Q1.14 twiddle ROM for an
// 8-point transform and the irdft FSM state type.
package rdft_pkg;

   localparam int unsigned TW_W    = 16;
   localparam int unsigned TW_FRAC = 14;

   // W(m) = cos(2*pi*m/8) + j*sin(2*pi*m/8), Q1.14
   localparam logic signed [TW_W-1:0] TW_COS [0:7] = '{
      16'sd16384, 16'sd11585, 16'sd0, -16'sd11585,
     -16'sd16384, -16'sd11585, 16'sd0, 16'sd11585
   };
   localparam logic signed [TW_W-1:0] TW_SIN [0:7] = '{
      16'sd0, 16'sd11585, 16'sd16384, 16'sd11585,
      16'sd0, -16'sd11585, -16'sd16384, -16'sd11585
   };

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_CALC = 2'd1,
      ST_EMIT = 2'd2
   } irdft_state_t;

endpackage

// File: rtl/cmul.sv
// Combinational complex multiply: (a_re + j a_im) * (w_re + j w_im).
// Ports: i_a_re/i_a_im data sample, i_w_re/i_w_im Q1.14 twiddle,
//        o_p_re/o_p_im full-precision product.
module cmul
   import rdft_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned PW = DW + TW_W + 2
) (
   input  logic signed [DW-1:0]   i_a_re,
   input  logic signed [DW-1:0]   i_a_im,
   input  logic signed [TW_W-1:0] i_w_re,
   input  logic signed [TW_W-1:0] i_w_im,
   output logic signed [PW-1:0]   o_p_re,
   output logic signed [PW-1:0]   o_p_im
);

   logic signed [PW-1:0] w_ac;
   logic signed [PW-1:0] w_bd;
   logic signed [PW-1:0] w_ad;
   logic signed [PW-1:0] w_bc;

   assign w_ac = PW'(i_a_re) * PW'(i_w_re);
   assign w_bd = PW'(i_a_im) * PW'(i_w_im);
   assign w_ad = PW'(i_a_re) * PW'(i_w_im);
   assign w_bc = PW'(i_a_im) * PW'(i_w_re);

   assign o_p_re = w_ac - w_bd;
   assign o_p_im = w_ad + w_bc;

endmodule

// File: rtl/irdft.sv
// Inverse DFT engine: loads N complex frequency samples, then computes each
// time sample with N sequential complex MACs plus one emit cycle, scaled 1/N.
// Ports: clk, rst_n (async, active low); in/j_in + in_valid sample input,
//        in_ready high while loading; out/j_out + out_valid result pulse,
//        frame_done pulses with the last sample of a frame.
module irdft
   import rdft_pkg::*;
#(
   parameter int unsigned BITS = 15,
   parameter int unsigned N    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic signed [BITS:0] in,
   input  logic signed [BITS:0] j_in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic signed [BITS:0] out,
   output logic signed [BITS:0] j_out,
   output logic                out_valid,
   output logic                frame_done
);

   localparam int unsigned DW    = BITS + 1;
   localparam int unsigned LOGN  = $clog2(N);
   localparam int unsigned PW    = DW + TW_W + 2;
   localparam int unsigned ACC_W = PW + LOGN;
   localparam int unsigned SHIFT = TW_FRAC + LOGN;

   localparam logic [LOGN-1:0]         K_LAST  = LOGN'(N - 1);
   localparam logic signed [ACC_W-1:0] RND     = ACC_W'(64'sd1 <<< (SHIFT - 1));
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< BITS) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   // Round half up, drop the Q1.14 and 1/N scaling, clamp to the sample range.
   function automatic logic signed [DW-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] v;
      v = (acc + RND) >>> SHIFT;
      if (v > SAT_MAX)      v = SAT_MAX;
      else if (v < SAT_MIN) v = SAT_MIN;
      return DW'(v);
   endfunction

   irdft_state_t            r_state;
   logic [LOGN-1:0]         r_k;
   logic [LOGN-1:0]         r_n;
   logic signed [ACC_W-1:0] r_acc_re;
   logic signed [ACC_W-1:0] r_acc_im;
   logic signed [DW-1:0]    r_out;
   logic signed [DW-1:0]    r_j_out;
   logic                    r_out_valid;
   logic                    r_frame_done;
   logic                    r_in_ready;
   logic signed [DW-1:0]    r_buf_re [0:N-1];
   logic signed [DW-1:0]    r_buf_im [0:N-1];

   irdft_state_t            w_state_nx;
   logic [LOGN-1:0]         w_k_nx;
   logic [LOGN-1:0]         w_n_nx;
   logic signed [ACC_W-1:0] w_acc_re_nx;
   logic signed [ACC_W-1:0] w_acc_im_nx;
   logic signed [DW-1:0]    w_out_nx;
   logic signed [DW-1:0]    w_j_out_nx;
   logic                    w_out_valid_nx;
   logic                    w_frame_done_nx;
   logic                    w_buf_we;

   logic [LOGN-1:0]         w_tw_idx;
   logic signed [TW_W-1:0]  w_tw_re;
   logic signed [TW_W-1:0]  w_tw_im;
   logic signed [DW-1:0]    w_x_re;
   logic signed [DW-1:0]    w_x_im;
   logic signed [PW-1:0]    w_p_re;
   logic signed [PW-1:0]    w_p_im;
   logic signed [ACC_W-1:0] w_sum_re;
   logic signed [ACC_W-1:0] w_sum_im;

   // Twiddle index n*k mod N: the low bits of the product wrap naturally.
   assign w_tw_idx = LOGN'(r_n * r_k);
   assign w_tw_re  = TW_COS[w_tw_idx];
   assign w_tw_im  = TW_SIN[w_tw_idx];
   assign w_x_re   = r_buf_re[r_k];
   assign w_x_im   = r_buf_im[r_k];

   cmul #(
      .DW (DW),
      .PW (PW)
   ) u_cmul (
      .i_a_re (w_x_re),
      .i_a_im (w_x_im),
      .i_w_re (w_tw_re),
      .i_w_im (w_tw_im),
      .o_p_re (w_p_re),
      .o_p_im (w_p_im)
   );

   assign w_sum_re = r_acc_re + ACC_W'(w_p_re);
   assign w_sum_im = r_acc_im + ACC_W'(w_p_im);

   // Next-state, counters, accumulator and output staging.
   always_comb begin
      w_state_nx      = r_state;
      w_k_nx          = r_k;
      w_n_nx          = r_n;
      w_acc_re_nx     = r_acc_re;
      w_acc_im_nx     = r_acc_im;
      w_out_nx        = r_out;
      w_j_out_nx      = r_j_out;
      w_out_valid_nx  = 1'b0;
      w_frame_done_nx = 1'b0;
      w_buf_we        = 1'b0;

      unique case (r_state)
         ST_LOAD: begin
            if (in_valid && r_in_ready) begin
               w_buf_we = 1'b1;
               w_k_nx   = r_k + LOGN'(1);
               if (r_k == K_LAST) begin
                  w_state_nx  = ST_CALC;
                  w_k_nx      = '0;
                  w_n_nx      = '0;
                  w_acc_re_nx = '0;
                  w_acc_im_nx = '0;
               end
            end
         end
         ST_CALC: begin
            w_acc_re_nx = w_sum_re;
            w_acc_im_nx = w_sum_im;
            w_k_nx      = r_k + LOGN'(1);
            // Result is registered on the last MAC so it is visible during EMIT.
            if (r_k == K_LAST) begin
               w_state_nx      = ST_EMIT;
               w_out_nx        = round_sat(w_sum_re);
               w_j_out_nx      = round_sat(w_sum_im);
               w_out_valid_nx  = 1'b1;
               w_frame_done_nx = (r_n == K_LAST);
            end
         end
         ST_EMIT: begin
            w_k_nx = '0;
            if (r_n != K_LAST) begin
               w_state_nx  = ST_CALC;
               w_n_nx      = r_n + LOGN'(1);
               w_acc_re_nx = '0;
               w_acc_im_nx = '0;
            end else begin
               w_state_nx = ST_LOAD;
               w_n_nx     = '0;
            end
         end
         default: begin
            w_state_nx = ST_LOAD;
            w_k_nx     = '0;
            w_n_nx     = '0;
         end
      endcase
   end

   // State and control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_LOAD;
         r_k          <= '0;
         r_n          <= '0;
         r_acc_re     <= '0;
         r_acc_im     <= '0;
         r_out        <= '0;
         r_j_out      <= '0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_in_ready   <= 1'b1;
      end else begin
         r_state      <= w_state_nx;
         r_k          <= w_k_nx;
         r_n          <= w_n_nx;
         r_acc_re     <= w_acc_re_nx;
         r_acc_im     <= w_acc_im_nx;
         r_out        <= w_out_nx;
         r_j_out      <= w_j_out_nx;
         r_out_valid  <= w_out_valid_nx;
         r_frame_done <= w_frame_done_nx;
         r_in_ready   <= (w_state_nx == ST_LOAD);
      end
   end

   // Sample buffer: overwritten on every load, never cleared.
   always_ff @(posedge clk) begin
      if (w_buf_we) begin
         r_buf_re[r_k] <= in;
         r_buf_im[r_k] <= j_in;
      end
   end

   assign in_ready   = r_in_ready;
   assign out        = r_out;
   assign j_out      = r_j_out;
   assign out_valid  = r_out_valid;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_irdft.sv
// Scoreboard bench for irdft: the driver pushes expected samples (with their
// expected arrival cycle), the monitor pops and compares on out_valid.
module tb_irdft;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic signed [15:0] tb_in;
   logic signed [15:0] tb_j_in;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] tb_out;
   logic signed [15:0] tb_j_out;
   logic               out_valid;
   logic               frame_done;

   irdft #(.BITS(15), .N(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (tb_in),
      .j_in       (tb_j_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out        (tb_out),
      .j_out      (tb_j_out),
      .out_valid  (out_valid),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int idx;
      int re;
      int im;
      bit chk_re;
      bit chk_im;
      int tol;
      bit last;
      int cyc;
   } exp_t;

   typedef int frame_t [8];

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   frame_t ZERO    = '{0, 0, 0, 0, 0, 0, 0, 0};
   frame_t IMP_RE  = '{8000, 0, 0, 0, 0, 0, 0, 0};
   frame_t TONE_RE = '{0, 8192, 0, 0, 0, 0, 0, 0};
   frame_t TONE_XR = '{1024, 724, 0, -724, -1024, -724, 0, 724};
   frame_t TONE_XI = '{0, 724, 1024, 724, 0, -724, -1024, -724};
   frame_t SAT_RE  = '{32767, 32767, 32767, -32767, -32767, -32767, 32767, 32767};
   frame_t SAT_IM  = '{-32767, -32767, -32767, -32767, -32767, 32767, 32767, 32767};

   task automatic check(input string name, input int act, input int req, input int tol);
      int d;
      d = act - req;
      if (d < 0) d = -d;
      n_tests++;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, req, tol);
      end
   endtask

   task automatic push_exp(input int idx, input int re, input int im, input bit cr,
                           input bit ci, input int tol, input int t0);
      exp_t e;
      e.idx    = idx;
      e.re     = re;
      e.im     = im;
      e.chk_re = cr;
      e.chk_im = ci;
      e.tol    = tol;
      e.last   = (idx == 7);
      e.cyc    = t0 + 9 * (idx + 1);
      sb.push_back(e);
   endtask

   task automatic push_frame(input frame_t xr, input frame_t xi, input int tol, input int t0);
      for (int n = 0; n < 8; n++) push_exp(n, xr[n], xi[n], 1'b1, 1'b1, tol, t0);
   endtask

   // Present one frame with handshake; t0 is the cycle in which X[7] is accepted.
   task automatic send_frame(input frame_t xr, input frame_t xi, output int t0);
      int guard;
      t0 = -1;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         tb_in    = 16'(xr[k]);
         tb_j_in  = 16'(xi[k]);
         guard    = 0;
         while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 200) check("in_ready timeout", 0, 1, 0);
         t0 = cyc;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      tb_in    = '0;
      tb_j_in  = '0;
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      if (sb.size() != 0) begin
         check("drain timeout, entries left", sb.size(), 0, 0);
         sb.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented output against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected out_valid", 1, 0, 0);
            end else begin
               e = sb.pop_front();
               if (e.chk_re) check($sformatf("x[%0d] re", e.idx), int'(tb_out), e.re, e.tol);
               if (e.chk_im) check($sformatf("x[%0d] im", e.idx), int'(tb_j_out), e.im, e.tol);
               check($sformatf("x[%0d] frame_done", e.idx), int'(frame_done), int'(e.last), 0);
               check($sformatf("x[%0d] cycle", e.idx), cyc, e.cyc, 0);
            end
         end else if (rst_n && frame_done) begin
            check("frame_done without out_valid", 1, 0, 0);
         end
      end
   end

   initial begin
      int t0;
      int t0a;
      int first2;
      int f;
      int idx;
      int guard;
      int xs[8];
      frame_t rt_re;
      frame_t rt_im;
      frame_t rt_x;
      real sr;
      real si;
      real ang;

      in_valid = 1'b0;
      tb_in    = '0;
      tb_j_in  = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out", int'(tb_out), 0, 0);
      check("reset j_out", int'(tb_j_out), 0, 0);
      check("reset out_valid", int'(out_valid), 0, 0);
      check("reset frame_done", int'(frame_done), 0, 0);
      check("reset in_ready", int'(in_ready), 1, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Impulse in bin 0
      send_frame(IMP_RE, ZERO, t0);
      check("in_ready low after load", int'(in_ready), 0, 0);
      for (int n = 0; n < 8; n++) push_exp(n, 1000, 0, 1'b1, 1'b1, 0, t0);
      wait_drain();

      // Single tone in bin 1
      send_frame(TONE_RE, ZERO, t0);
      push_frame(TONE_XR, TONE_XI, 0, t0);
      wait_drain();

      // Saturation: only x[1] real is meaningful
      send_frame(SAT_RE, SAT_IM, t0);
      for (int n = 0; n < 8; n++) push_exp(n, 32767, 0, (n == 1), 1'b0, 0, t0);
      wait_drain();

      // Flow control: in_valid held high across two frames
      f = 0; idx = 0; t0a = 0; first2 = -1; guard = 0;
      in_valid = 1'b1;
      while (f < 2 && guard < 500) begin
         if (in_ready) begin
            tb_in   = (f == 0) ? 16'(IMP_RE[idx]) : 16'(TONE_RE[idx]);
            tb_j_in = '0;
            if (f == 1 && idx == 0) first2 = cyc;
            if (idx == 7) begin
               if (f == 0) begin
                  t0a = cyc;
                  for (int n = 0; n < 8; n++) push_exp(n, 1000, 0, 1'b1, 1'b1, 0, cyc);
               end else begin
                  push_frame(TONE_XR, TONE_XI, 0, cyc);
               end
               idx = 0;
               f++;
            end else begin
               idx++;
            end
         end else begin
            tb_in   = 16'sd12345;
            tb_j_in = -16'sd777;
         end
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b0;
      tb_in    = '0;
      tb_j_in  = '0;
      check("flow frames loaded", f, 2, 0);
      check("second frame start cycle", first2, t0a + 73, 0);
      wait_drain();

      // Reset just after x[0] is emitted
      send_frame(IMP_RE, ZERO, t0);
      for (int n = 0; n < 8; n++) push_exp(n, 1000, 0, 1'b1, 1'b1, 0, t0);
      guard = 0;
      while (cyc < t0 + 12 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("entries left before reset", sb.size(), 7, 0);
      rst_n = 1'b0;
      #1;
      check("mid reset out", int'(tb_out), 0, 0);
      check("mid reset j_out", int'(tb_j_out), 0, 0);
      check("mid reset out_valid", int'(out_valid), 0, 0);
      check("mid reset in_ready", int'(in_ready), 1, 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      send_frame(IMP_RE, ZERO, t0);
      for (int n = 0; n < 8; n++) push_exp(n, 1000, 0, 1'b1, 1'b1, 0, t0);
      wait_drain();

      // Round trip: forward DFT of a random real frame, inverse must restore it
      for (int n = 0; n < 8; n++) xs[n] = int'($urandom_range(8000)) - 4000;
      for (int k = 0; k < 8; k++) begin
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < 8; n++) begin
            ang = 2.0 * 3.14159265358979 * real'(n * k) / 8.0;
            sr  = sr + real'(xs[n]) * $cos(ang);
            si  = si - real'(xs[n]) * $sin(ang);
         end
         rt_re[k] = int'(sr);
         rt_im[k] = int'(si);
         rt_x[k]  = xs[k];
      end
      send_frame(rt_re, rt_im, t0);
      push_frame(rt_x, ZERO, 2, t0);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/irdft.md
# irdft

Inverse real/complex DFT engine that accepts a frame of N complex frequency-domain samples (real on `in`, imaginary on `j_in`) and emits the N time-domain samples on `out`/`j_out`. It sits on the output side of the `rdft` datapath and turns the transform's results back into samples. It uses one sequential complex multiply-accumulate per output: N MAC cycles plus one emit cycle per output sample. Scaling by 1/N is built in, so a frame passed through `rdft` and then `irdft` returns at unity gain, apart from rounding.

## Interface
- `BITS`, default 15: sample MSB index; samples are signed `[BITS:0]`, 16 bits at the default.
- `N`, default 8: frame length, a power of 2; only 8 is supported with the package twiddle table.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active low.
- `in`, input, `[BITS:0]` signed: real part of frequency sample X[k].
- `j_in`, input, `[BITS:0]` signed: imaginary part of X[k].
- `in_valid`, input, 1: `in`/`j_in` carry a sample this cycle.
- `in_ready`, output, 1: block accepts samples; high only in LOAD.
- `out`, output, `[BITS:0]` signed: real part of x[n], registered.
- `j_out`, output, `[BITS:0]` signed: imaginary part of x[n], registered.
- `out_valid`, output, 1: one-cycle pulse per output sample; there is no backpressure.
- `frame_done`, output, 1: pulses together with `out_valid` for x[N-1].

## Operation
- FSM states are LOAD, CALC and EMIT. Reset state is LOAD with k=0 and n=0.
- **LOAD**
  - A sample is accepted on `in_valid && in_ready`. It is stored in buffer[k], and k increments.
  - On acceptance of k=N-1, go to CALC with n=0, k=0 and the accumulator cleared.
- **CALC**
  - One MAC per cycle for k=0..N-1: acc += X[k]·W(n·k mod N).
  - W(m) = cos(2πm/N) + j·sin(2πm/N), which is the inverse (positive-exponent) twiddle.
  - The twiddle index is the low log2(N) bits of n·k, so it wraps naturally.
  - After k=N-1, go to EMIT.
- **EMIT**
  - Register `out`/`j_out` from the scaled accumulator and pulse `out_valid`.
  - If n<N-1: n++, k=0, clear the accumulator, return to CALC.
  - Otherwise pulse `frame_done` and return to LOAD with k=0.
- **Arithmetic**
  - Twiddles are signed 16-bit Q1.14: 1.0=16384, √2/2=11585.
  - Complex product real part = a·c − b·d; imaginary part = a·d + b·c. Each is 34-bit signed.
  - The accumulator is 34+log2(N) bits, signed.
  - Output = (acc + 2^(13+log2 N)) >>> (14+log2 N). This is round-half-up, followed by saturation to [−2^BITS, 2^BITS−1].
- `in_valid` outside LOAD is ignored and data is dropped. The upstream must respect `in_ready`.
- The buffer is not cleared by reset. It is overwritten on every load.

## Timing
- Reset values: `out`=0, `j_out`=0, `out_valid`=0, `frame_done`=0, `in_ready`=1.
- If reset is asserted mid-frame, the FSM immediately returns to LOAD with k=0. The partial frame is discarded, and no `out_valid` occurs until a full new frame is loaded.
- Let t0 be the cycle in which X[N-1] is accepted.
  - First MAC happens at t0+1.
  - x[n] is visible with `out_valid` at t0+(n+1)(N+1). With N=8 that is t0+9, t0+18, …, t0+72.
- `in_ready` rises at t0+(N+1)·N+1 (t0+73 for N=8).
- The earliest back-to-back frame period is N + N(N+1) = 80 cycles.
- `in_ready` is low from t0+1 through the final EMIT cycle.

## Structure
- The shared package `rdft_pkg` holds:
  - the twiddle ROM constants `TW_COS[0:7]` and `TW_SIN[0:7]` in Q1.14;
  - `TW_FRAC`=14;
  - the FSM state enum `irdft_state_t`.
- Factor the complex multiply into one sub-module, `cmul`: combinational, with the two 16-bit complex inputs and a 34-bit complex product. `rdft` reuses it.
- Buffer, counters, FSM, accumulator and output round/saturate stay in `irdft`.

## Test plan
- **Impulse in bin 0:** X[0]=(8000,0), other bins 0 → all 8 outputs are (1000,0). Pulses land at t0+9·(n+1); `frame_done` comes with x[7].
- **Single tone:** X[1]=(8192,0), other bins 0 → x[0]=(1024,0), x[1]=(724,724), x[2]=(0,1024), x[4]=(−1024,0), x[7]=(724,−724).
- **Saturation:**
  - Stimulus: X[k]=(32767·s_c, −32767·s_s), where s_c = sign of cos(2πk/8) and s_s = sign of sin(2πk/8), with sign(0)=+1.
  - Response: x[1] real computes to about 39553 and must appear as 32767.
  - No other output sample is checked in this scenario.
- **Flow control:** hold `in_valid`=1 continuously across 2 frames. Only the 8 samples presented while `in_ready`=1 are captured, and the second frame loads starting at t0+73.
- **Reset mid-operation:** deassert `rst_n` at t0+12, just after x[0] is emitted. Outputs read 0 and `in_ready`=1 immediately. A fresh impulse frame then yields the correct (1000,0) outputs.
- **Round trip:** random 16-bit time frame → `rdft` → `irdft` gives the original samples within ±2 LSB.
